// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: scans two WIDTH-bit operands MSB-first, DIGIT bits per clock.
// Latency: 1 + k cycles from accept to out_valid (k = slices scanned, 1..N; k = N when EARLY_EXIT = 0).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, with no bypass back into SCAN.
//
// Ports:
//    clk, rst_n          - clock (rising edge), asynchronous active-low reset
//    in_valid/in_ready   - operand handshake (a, b, is_signed, op)
//    out_valid/out_ready - result handshake (lt, eq, gt, y, busy_cycles)
//    busy_cycles         - scan cycles spent on the current result
module seq_magnitude_comparator #(
   parameter int WIDTH      = 32,
   parameter int DIGIT      = 8,
   parameter int EARLY_EXIT = 1,
   localparam int N         = WIDTH / DIGIT,
   localparam int CW        = $clog2(N) + 1,
   localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic             y,
   output logic [CW-1:0]    busy_cycles
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sgn_q;
   logic [1:0]       op_q;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic             dec_q, dec_lt_q, dec_gt_q;

   logic [DIGIT-1:0] sa, sb;
   logic             slice_neq, slice_lt, last;
   logic             res_lt, res_eq, res_gt, res_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_ready = (state == IDLE);
      sa       = a_q[int'(idx)*DIGIT +: DIGIT];
      sb       = b_q[int'(idx)*DIGIT +: DIGIT];
      // Flipping the sign bit of the top slice maps two's complement onto
      // unsigned order, so the same slice compare handles both modes.
      if (sgn_q && (idx == IW'(N-1))) begin
         sa[DIGIT-1] = ~sa[DIGIT-1];
         sb[DIGIT-1] = ~sb[DIGIT-1];
      end
      slice_neq = (sa != sb);
      slice_lt  = (sa < sb);
      // An earlier decision always wins over the slice being looked at now.
      res_lt = dec_q ? dec_lt_q : (slice_neq & slice_lt);
      res_gt = dec_q ? dec_gt_q : (slice_neq & ~slice_lt);
      res_eq = ~(dec_q | slice_neq);
      unique case (op_q)
         2'd0:    res_y = res_lt;
         2'd1:    res_y = res_lt | res_eq;
         2'd2:    res_y = res_gt;
         default: res_y = res_gt | res_eq;
      endcase
      last = (idx == '0) || ((EARLY_EXIT != 0) && slice_neq);
      unique case (state)
         IDLE:    if (in_valid)  state_n = SCAN;
         SCAN:    if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         op_q        <= 2'd0;
         idx         <= '0;
         cnt         <= '0;
         dec_q       <= 1'b0;
         dec_lt_q    <= 1'b0;
         dec_gt_q    <= 1'b0;
         out_valid   <= 1'b0;
         lt          <= 1'b0;
         eq          <= 1'b0;
         gt          <= 1'b0;
         y           <= 1'b0;
         busy_cycles <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  sgn_q <= is_signed;
                  op_q  <= op;
                  idx   <= IW'(N-1);
                  cnt   <= '0;
                  dec_q <= 1'b0;
               end
            end
            SCAN: begin
               cnt <= cnt + CW'(1);
               if (slice_neq && !dec_q) begin
                  dec_q    <= 1'b1;
                  dec_lt_q <= slice_lt;
                  dec_gt_q <= ~slice_lt;
               end
               if (last) begin
                  lt          <= res_lt;
                  eq          <= res_eq;
                  gt          <= res_gt;
                  y           <= res_y;
                  busy_cycles <= cnt + CW'(1);
                  out_valid   <= 1'b1;
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: four configurations run in lockstep
// (32/8 early-exit, 32/8 constant-time, 64/4 early-exit, 32/32 single slice)
// against a reference model built from plain signed/unsigned arithmetic.
module tb_seq_magnitude_comparator;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, is_signed, out_ready;
   logic [63:0] a_in, b_in;
   logic [1:0]  op;
   logic [3:0]  ir, ov, lt_o, eq_o, gt_o, y_o;
   logic [2:0]  bc0, bc1;
   logic [4:0]  bc2;
   logic [0:0]  bc3;

   int checks = 0;
   int failures = 0;

   localparam int WID [4] = '{32, 32, 64, 32};
   localparam int DIG [4] = '{8, 8, 4, 32};
   localparam int EEX [4] = '{1, 0, 1, 1};

   bit pend [4];
   bit e_lt [4], e_eq [4], e_gt [4], e_y [4];
   int e_busy [4];
   logic [3:0] c_lt, c_eq, c_gt, c_y;
   int c_bc0, c_bc1;

   seq_magnitude_comparator #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a_in[31:0]), .b(b_in[31:0]), .is_signed(is_signed), .op(op),
      .out_valid(ov[0]), .out_ready(out_ready), .lt(lt_o[0]), .eq(eq_o[0]),
      .gt(gt_o[0]), .y(y_o[0]), .busy_cycles(bc0));
   seq_magnitude_comparator #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(0)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a_in[31:0]), .b(b_in[31:0]), .is_signed(is_signed), .op(op),
      .out_valid(ov[1]), .out_ready(out_ready), .lt(lt_o[1]), .eq(eq_o[1]),
      .gt(gt_o[1]), .y(y_o[1]), .busy_cycles(bc1));
   seq_magnitude_comparator #(.WIDTH(64), .DIGIT(4), .EARLY_EXIT(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a_in), .b(b_in), .is_signed(is_signed), .op(op),
      .out_valid(ov[2]), .out_ready(out_ready), .lt(lt_o[2]), .eq(eq_o[2]),
      .gt(gt_o[2]), .y(y_o[2]), .busy_cycles(bc2));
   seq_magnitude_comparator #(.WIDTH(32), .DIGIT(32), .EARLY_EXIT(1)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
      .a(a_in[31:0]), .b(b_in[31:0]), .is_signed(is_signed), .op(op),
      .out_valid(ov[3]), .out_ready(out_ready), .lt(lt_o[3]), .eq(eq_o[3]),
      .gt(gt_o[3]), .y(y_o[3]), .busy_cycles(bc3));

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int busy_of(input int i);
      case (i)
         0:       return int'(bc0);
         1:       return int'(bc1);
         2:       return int'(bc2);
         default: return int'(bc3);
      endcase
   endfunction

   // Reference: signed values are sign-extended to 64 bits and compared as
   // longint; the scan length is read off the highest differing bit.
   function automatic void model(input logic [63:0] ta, input logic [63:0] tb,
                                 input bit s, input logic [1:0] top,
                                 input int w, input int d, input int ee,
                                 output bit mlt, output bit meq, output bit mgt,
                                 output bit my, output int mbusy);
      logic [63:0] m, x, ea, eb;
      longint sa, sb;
      int hi;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      ea = ta & m;
      eb = tb & m;
      if (s) begin
         sa  = $signed(ea | ({64{ea[w-1]}} & ~m));
         sb  = $signed(eb | ({64{eb[w-1]}} & ~m));
         mlt = sa < sb;
         mgt = sa > sb;
      end else begin
         mlt = ea < eb;
         mgt = ea > eb;
      end
      meq = (ea == eb);
      case (top)
         2'd0:    my = mlt;
         2'd1:    my = mlt | meq;
         2'd2:    my = mgt;
         default: my = mgt | meq;
      endcase
      x = ea ^ eb;
      if (x == 0 || ee == 0) mbusy = w / d;
      else begin
         hi = 0;
         for (int i = 0; i < 64; i++) if (x[i]) hi = i;
         mbusy = w / d - hi / d;
      end
   endfunction

   // Compare process: any valid result must match the model on every cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (ov[i]) begin
               chk($sformatf("valid_expected_u%0d", i), longint'(pend[i]), 1);
               if (pend[i]) begin
                  chk($sformatf("lt_u%0d", i), longint'(lt_o[i]), longint'(e_lt[i]));
                  chk($sformatf("eq_u%0d", i), longint'(eq_o[i]), longint'(e_eq[i]));
                  chk($sformatf("gt_u%0d", i), longint'(gt_o[i]), longint'(e_gt[i]));
                  chk($sformatf("y_u%0d", i), longint'(y_o[i]), longint'(e_y[i]));
                  chk($sformatf("busy_u%0d", i), longint'(busy_of(i)), longint'(e_busy[i]));
                  chk($sformatf("onehot_u%0d", i),
                      longint'(int'(lt_o[i]) + int'(eq_o[i]) + int'(gt_o[i])), 1);
               end
            end
         end
      end
   end

   task automatic arm(input logic [63:0] ta, input logic [63:0] tb, input bit s, input logic [1:0] top);
      @(negedge clk);
      chk("in_ready_idle", longint'(ir), 4'hF);
      a_in = ta; b_in = tb; is_signed = s; op = top; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         model(ta, tb, s, top, WID[i], DIG[i], EEX[i], e_lt[i], e_eq[i], e_gt[i], e_y[i], e_busy[i]);
         pend[i] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      // Scramble the inputs: the accepted operands must already be shadowed.
      in_valid = 1'b0; a_in = ~ta; b_in = tb ^ 64'h5A5A_A5A5_0FF0_F00F;
      is_signed = ~s; op = ~top;
   endtask

   task automatic txn(input logic [63:0] ta, input logic [63:0] tb, input bit s,
                      input logic [1:0] top, input int hold, output int lat0, output int lat1);
      int cyc;
      arm(ta, tb, s, top);
      cyc = 1; lat0 = 0; lat1 = 0;
      forever begin
         if (ov[0] && lat0 == 0) lat0 = cyc;
         if (ov[1] && lat1 == 0) lat1 = cyc;
         if (ov == 4'hF || cyc >= 60) break;
         @(negedge clk);
         cyc++;
      end
      if (ov != 4'hF) chk("done_timeout", longint'(ov), 4'hF);
      c_lt = lt_o; c_eq = eq_o; c_gt = gt_o; c_y = y_o;
      c_bc0 = int'(bc0); c_bc1 = int'(bc1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("stall_in_ready", longint'(ir), 0);
         chk("stall_hold", longint'({lt_o, eq_o, gt_o, y_o, ov}), longint'({c_lt, c_eq, c_gt, c_y, 4'hF}));
         in_valid = 1'b1; a_in = 64'h1; b_in = 64'h2;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) pend[i] = 1'b0;
      chk("release_out_valid", longint'(ov), 0);
      chk("release_in_ready", longint'(ir), 4'hF);
   endtask

   initial begin
      int l0, l1, sel;
      logic [63:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0; op = 2'd0;
      a_in = '0; b_in = '0;
      for (int i = 0; i < 4; i++) pend[i] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", longint'(ir), 4'hF);
      chk("rst_out_valid", longint'(ov), 0);
      chk("rst_flags", longint'({lt_o, eq_o, gt_o, y_o}), 0);
      chk("rst_busy", longint'({bc0, bc1, bc2, bc3}), 0);
      rst_n = 1'b1;

      // Unsigned equal, op A<=B.
      txn(64'h12345678, 64'h12345678, 1'b0, 2'd1, 0, l0, l1);
      chk("eq_case_eq", longint'(c_eq[0]), 1);
      chk("eq_case_y", longint'(c_y[0]), 1);
      chk("eq_case_busy", c_bc0, 4);
      chk("eq_case_lat", l0, 5);

      // Unsigned, decided in the top slice.
      txn(64'h80000000, 64'h7FFFFFFF, 1'b0, 2'd1, 0, l0, l1);
      chk("top_gt", longint'(c_gt[0]), 1);
      chk("top_y", longint'(c_y[0]), 0);
      chk("top_busy", c_bc0, 1);
      chk("top_lat", l0, 2);
      chk("top_ct_busy", c_bc1, 4);
      chk("top_ct_lat", l1, 5);

      // Signed: most negative vs +1, op A<B.
      txn(64'h80000000, 64'h00000001, 1'b1, 2'd0, 0, l0, l1);
      chk("sgn_min_lt", longint'(c_lt[0]), 1);
      chk("sgn_min_y", longint'(c_y[0]), 1);

      // Signed -1 vs -2: decided only in the bottom slice.
      txn(64'hFFFFFFFF, 64'hFFFFFFFE, 1'b1, 2'd0, 0, l0, l1);
      chk("sgn_m1_gt", longint'(c_gt[0]), 1);
      chk("sgn_m1_y", longint'(c_y[0]), 0);
      chk("sgn_m1_busy", c_bc0, 4);

      // Constant-time configuration.
      txn(64'hFF000000, 64'h00000000, 1'b0, 2'd2, 0, l0, l1);
      chk("ct_gt", longint'(c_gt[1]), 1);
      chk("ct_busy", c_bc1, 4);
      chk("ct_lat", l1, 5);

      // Backpressure: 10 stalled cycles with a competing in_valid.
      txn(64'h00000010, 64'h00000020, 1'b0, 2'd3, 10, l0, l1);
      chk("bp_lt", longint'(c_lt[0]), 1);
      chk("bp_y", longint'(c_y[0]), 0);
      repeat (3) @(negedge clk);
      chk("bp_no_accept", longint'(ov), 0);

      // Reset during the second scan cycle.
      arm(64'h0, 64'h0, 1'b0, 2'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) pend[i] = 1'b0;
      #1;
      chk("midrst_out_valid", longint'(ov), 0);
      chk("midrst_in_ready", longint'(ir), 4'hF);
      @(negedge clk);
      rst_n = 1'b1;
      txn(64'd5, 64'd9, 1'b0, 2'd3, 0, l0, l1);
      chk("post_rst_lt", longint'(c_lt[0]), 1);
      chk("post_rst_y", longint'(c_y[0]), 0);

      // Random regression with a bias toward long shared prefixes.
      for (int n = 0; n < 1500; n++) begin
         ra  = {$urandom, $urandom};
         sel = $urandom_range(0, 3);
         case (sel)
            0:       rb = {$urandom, $urandom};
            1:       rb = ra;
            2:       rb = ra ^ (64'd1 << $urandom_range(0, 63));
            default: rb = ra ^ (64'(2 ** $urandom_range(0, 8)) - 64'd1);
         endcase
         txn(ra, rb, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, l0, l1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
